bank_rd_ctrl: RTL

BANK_RD_CTRL -- requirements
Module: bank_rd_ctrl

---
 rtl/bank_rd_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/bank_rd_ctrl.sv
// Banked read controller: decodes bank enables, tracks accepted reads through a
// fixed-latency select pipeline, captures mux data and counts reads in flight.
module bank_rd_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_en,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [3:0]            o_bank_en,
    output logic [ADDR_WIDTH-3:0] o_local_addr,
    output logic [1:0]            o_sel,
    output logic                  o_sel_valid,
    input  logic [DATA_WIDTH-1:0] i_mux_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_drop,
    output logic [2:0]            o_pending
);

    localparam int unsigned LAST    = READ_LATENCY - 1;
    localparam int unsigned PEND_MAX = READ_LATENCY + 1;

    logic [1:0]              w_bank;
    logic                    w_accept;
    logic [READ_LATENCY-1:0] w_in_vld;
    logic [1:0]              w_in_bank [READ_LATENCY];

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [1:0]              r_pipe_bank [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic                    r_rd_drop;
    logic [2:0]              r_pending;

    // Write wins a read/write collision, so only a lone read enters the pipeline.
    assign w_bank       = i_addr[ADDR_WIDTH-1 -: 2];
    assign w_accept     = i_rd_en & ~i_wr_en;
    assign o_bank_en    = (i_rd_en | i_wr_en) ? 4'(4'b0001 << w_bank) : 4'b0000;
    assign o_local_addr = i_addr[ADDR_WIDTH-3:0];

    always_comb begin
        w_in_vld     = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            w_in_bank[i] = 2'b00;
        end
        w_in_vld[0]  = w_accept;
        w_in_bank[0] = w_bank;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            w_in_vld[i]  = r_pipe_vld[i-1];
            w_in_bank[i] = r_pipe_bank[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                r_pipe_bank[i] <= 2'b00;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_drop  <= 1'b0;
            r_pending  <= 3'd0;
        end else begin
            for (int i = 0; i < int'(LAST); i++) begin
                r_pipe_vld[i]  <= w_in_vld[i];
                r_pipe_bank[i] <= w_in_bank[i];
            end
            // Final stage drives the mux select, so it only moves on a valid read.
            r_pipe_vld[LAST] <= w_in_vld[LAST];
            if (w_in_vld[LAST]) begin
                r_pipe_bank[LAST] <= w_in_bank[LAST];
            end

            if (r_pipe_vld[LAST]) begin
                r_rd_data <= i_mux_data;
            end
            r_rd_valid <= r_pipe_vld[LAST];
            r_rd_drop  <= i_rd_en & i_wr_en;

            case ({w_accept, r_rd_valid})
                2'b10: if (r_pending < 3'(PEND_MAX)) r_pending <= r_pending + 3'd1;
                2'b01: if (r_pending != 3'd0)        r_pending <= r_pending - 3'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign o_sel       = r_pipe_bank[LAST];
    assign o_sel_valid = r_pipe_vld[LAST];
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_drop   = r_rd_drop;
    assign o_pending   = r_pending;

endmodule
